seven_segment_controller: RTL and testbench

//   Downstream display stage for the 16-bit event counter. Takes a 16-bit

---
 rtl/seven_segment_controller.sv | 103 ++++++++++
 tb/tb_seven_segment_controller.sv | 137 +++++++++++++
 2 files changed

// File: rtl/seven_segment_controller.sv
// rtl/seven_segment_controller.sv - 4-digit multiplexed hex display driver with scan-wrap snapshot
//
// Shows a 16-bit value as four hex digits on a common-anode, time-multiplexed
// 7-segment display. One digit is lit at a time. The lit digit advances
// every COUNT_PERIOD clocks. The input is captured once per full scan, so
// all four digits always come from the same value.
//
// Ports:
//   clk_in   in   1   system clock
//   rst_in   in   1   asynchronous active-high reset
//   val_in   in   16  value to display, sampled only when the scan wraps 3->0
//   cat_out  out  7   segment cathodes, active-low, {g,f,e,d,c,b,a}
//   an_out   out  4   digit anodes, active-low, an_out[0] = rightmost digit
module seven_segment_controller #(
   parameter int COUNT_PERIOD  = 100_000,
   parameter bit BLANK_LEADING = 1'b0
) (
   input  logic        clk_in,
   input  logic        rst_in,
   input  logic [15:0] val_in,
   output logic [6:0]  cat_out,
   output logic [3:0]  an_out
);

   localparam int            CW      = (COUNT_PERIOD > 1) ? $clog2(COUNT_PERIOD) : 1;
   localparam logic [CW-1:0] CNT_MAX = CW'(COUNT_PERIOD - 1);
   localparam logic [CW-1:0] CNT_ONE = CW'(1);

   logic [CW-1:0] cnt;
   logic [1:0]    idx;
   logic [15:0]   snap;

   logic [3:0]    nibble;
   logic          blank;
   logic [6:0]    seg;

   always_ff @(posedge clk_in or posedge rst_in) begin
      if (rst_in) begin
         cnt  <= '0;
         idx  <= 2'd0;
         snap <= 16'h0000;
      end else if (cnt == CNT_MAX) begin
         cnt <= '0;
         idx <= idx + 2'd1;
         // Capture only as the scan restarts at digit 0, so a full pass of
         // the display never mixes digits from two different values.
         if (idx == 2'd3) begin
            snap <= val_in;
         end
      end else begin
         cnt <= cnt + CNT_ONE;
      end
   end

   always_comb begin
      nibble = snap[3:0];
      blank  = 1'b0;
      case (idx)
         2'd0: nibble = snap[3:0];
         2'd1: nibble = snap[7:4];
         2'd2: nibble = snap[11:8];
         2'd3: nibble = snap[15:12];
         default: nibble = snap[3:0];
      endcase
      // A digit is a leading zero when it and every digit to its left are
      // zero. Digit 0 always shows so a value of zero still reads "0".
      if (BLANK_LEADING) begin
         case (idx)
            2'd1: blank = (snap[15:4] == 12'h000);
            2'd2: blank = (snap[15:8] == 8'h00);
            2'd3: blank = (snap[15:12] == 4'h0);
            default: blank = 1'b0;
         endcase
      end
   end

   always_comb begin
      seg = 7'h7F;
      case (nibble)
         4'h0: seg = 7'h40;
         4'h1: seg = 7'h79;
         4'h2: seg = 7'h24;
         4'h3: seg = 7'h30;
         4'h4: seg = 7'h19;
         4'h5: seg = 7'h12;
         4'h6: seg = 7'h02;
         4'h7: seg = 7'h78;
         4'h8: seg = 7'h00;
         4'h9: seg = 7'h10;
         4'hA: seg = 7'h08;
         4'hB: seg = 7'h03;
         4'hC: seg = 7'h46;
         4'hD: seg = 7'h21;
         4'hE: seg = 7'h06;
         4'hF: seg = 7'h0E;
         default: seg = 7'h7F;
      endcase
   end

   assign cat_out = blank ? 7'h7F : seg;
   assign an_out  = ~(4'b0001 << idx);

endmodule

// File: tb/tb_seven_segment_controller.sv
// tb/tb_seven_segment_controller.sv - directed scoreboard bench for seven_segment_controller
module tb_seven_segment_controller;

   logic        clk = 1'b0;
   always #5 clk = ~clk;

   // a: COUNT_PERIOD=4, no blanking; b: COUNT_PERIOD=4, blanking; c: COUNT_PERIOD=1
   logic        rst_a, rst_b, rst_c;
   logic [15:0] val_a, val_b, val_c;
   logic [6:0]  cat_a, cat_b, cat_c;
   logic [3:0]  an_a, an_b, an_c;

   seven_segment_controller #(.COUNT_PERIOD(4), .BLANK_LEADING(1'b0)) dut_a (
      .clk_in(clk), .rst_in(rst_a), .val_in(val_a), .cat_out(cat_a), .an_out(an_a));
   seven_segment_controller #(.COUNT_PERIOD(4), .BLANK_LEADING(1'b1)) dut_b (
      .clk_in(clk), .rst_in(rst_b), .val_in(val_b), .cat_out(cat_b), .an_out(an_b));
   seven_segment_controller #(.COUNT_PERIOD(1), .BLANK_LEADING(1'b0)) dut_c (
      .clk_in(clk), .rst_in(rst_c), .val_in(val_c), .cat_out(cat_c), .an_out(an_c));

   typedef struct {
      string      tag;
      int         sel;
      logic [3:0] an;
      logic [6:0] cat;
   } exp_t;

   exp_t exp_q[$];
   int   vectors = 0;
   int   miscompares = 0;

   task automatic push(input string tag, input int sel, input logic [3:0] an, input logic [6:0] cat);
      exp_t e;
      e.tag = tag;
      e.sel = sel;
      e.an  = an;
      e.cat = cat;
      exp_q.push_back(e);
   endtask

   task automatic step(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic check();
      exp_t       e;
      logic [3:0] an_obs;
      logic [6:0] cat_obs;
      vectors++;
      if (exp_q.size() == 0) begin
         miscompares++;
         $error("FAIL scoreboard_empty observed=0 expected=1");
      end else begin
         e = exp_q.pop_front();
         case (e.sel)
            0: begin an_obs = an_a; cat_obs = cat_a; end
            1: begin an_obs = an_b; cat_obs = cat_b; end
            default: begin an_obs = an_c; cat_obs = cat_c; end
         endcase
         assert (an_obs === e.an) else begin
            miscompares++;
            $error("FAIL %s an_out observed=%b expected=%b", e.tag, an_obs, e.an);
         end
         vectors++;
         assert (cat_obs === e.cat) else begin
            miscompares++;
            $error("FAIL %s cat_out observed=%h expected=%h", e.tag, cat_obs, e.cat);
         end
      end
   endtask

   initial begin
      rst_a = 1'b1; rst_b = 1'b1; rst_c = 1'b1;
      val_a = 16'h12AF; val_b = 16'h0040; val_c = 16'h0005;
      #1;
      push("reset_a_noclk", 0, 4'b1110, 7'h40); check();
      push("reset_b_noclk", 1, 4'b1110, 7'h40); check();
      push("reset_c_noclk", 2, 4'b1110, 7'h40); check();

      // DUT a: reset release, hold for 4 edges, then first snapshot at edge 16
      @(negedge clk);
      rst_a = 1'b0;
      push("hold_e3", 0, 4'b1110, 7'h40); step(3);  check();
      push("adv_e4",  0, 4'b1101, 7'h40); step(1);  check();
      push("12AF_d0", 0, 4'b1110, 7'h0E); step(12); check();
      push("12AF_d1", 0, 4'b1101, 7'h08); step(4);  check();
      push("12AF_d2", 0, 4'b1011, 7'h24); step(4);  check();
      push("12AF_d3", 0, 4'b0111, 7'h79); step(4);  check();

      // Tearing: load 1234, change input to 5678 mid-scan
      val_a = 16'h1234;
      push("1234_d0", 0, 4'b1110, 7'h19); step(4);  check();
      push("1234_d2", 0, 4'b1011, 7'h24); step(8);  check();
      val_a = 16'h5678;
      push("tear_d2", 0, 4'b1011, 7'h24); step(0);  check();
      push("tear_d3", 0, 4'b0111, 7'h79); step(4);  check();
      push("5678_d0", 0, 4'b1110, 7'h00); step(4);  check();
      push("5678_d1", 0, 4'b1101, 7'h78); step(4);  check();

      // Async reset mid-cycle with snap=BEEF at digit 3
      val_a = 16'hBEEF;
      push("BEEF_d0", 0, 4'b1110, 7'h0E); step(12); check();
      push("BEEF_d3", 0, 4'b0111, 7'h03); step(12); check();
      #2 rst_a = 1'b1;
      #1;
      push("async_rst", 0, 4'b1110, 7'h40); check();
      @(negedge clk);
      rst_a = 1'b0;
      push("post_rst_hold", 0, 4'b1110, 7'h40); step(3); check();
      push("post_rst_d1",   0, 4'b1101, 7'h40); step(1); check();

      // DUT b: leading-zero blanking
      rst_b = 1'b0;
      push("blk0040_d0", 1, 4'b1110, 7'h40); step(16); check();
      push("blk0040_d1", 1, 4'b1101, 7'h19); step(4);  check();
      push("blk0040_d2", 1, 4'b1011, 7'h7F); step(4);  check();
      push("blk0040_d3", 1, 4'b0111, 7'h7F); step(4);  check();
      val_b = 16'h0000;
      push("blk0000_d0", 1, 4'b1110, 7'h40); step(4);  check();
      push("blk0000_d1", 1, 4'b1101, 7'h7F); step(4);  check();
      push("blk0000_d2", 1, 4'b1011, 7'h7F); step(4);  check();
      push("blk0000_d3", 1, 4'b0111, 7'h7F); step(4);  check();

      // DUT c: COUNT_PERIOD=1 advances every edge, reloads every 4th
      rst_c = 1'b0;
      push("cp1_e1", 2, 4'b1101, 7'h40); step(1); check();
      push("cp1_e2", 2, 4'b1011, 7'h40); step(1); check();
      push("cp1_e3", 2, 4'b0111, 7'h40); step(1); check();
      push("cp1_e4", 2, 4'b1110, 7'h12); step(1); check();
      val_c = 16'h0009;
      push("cp1_e5", 2, 4'b1101, 7'h40); step(1); check();
      push("cp1_e8", 2, 4'b1110, 7'h10); step(3); check();

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
